// File: rtl/prm_scan_pkg.sv
// Shared types and constants for the PRM obstacle scan driver.
// Obstacle code bit positions follow the checker inputs A..O.
package prm_scan_pkg;

  localparam int CODE_W_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int BIT_A = 0;
  localparam int BIT_B = 1;
  localparam int BIT_C = 2;
  localparam int BIT_D = 3;
  localparam int BIT_E = 4;
  localparam int BIT_F = 5;
  localparam int BIT_G = 6;
  localparam int BIT_H = 7;
  localparam int BIT_I = 8;
  localparam int BIT_J = 9;
  localparam int BIT_K = 10;
  localparam int BIT_L = 11;
  localparam int BIT_M = 12;
  localparam int BIT_N = 13;
  localparam int BIT_O = 14;

endpackage

// File: rtl/prm_edge_accum.sv
// Blocked-edge bitmap: ORs the checker bank's edge mask in while a code is pending.
module prm_edge_accum #(
  parameter int NUM_EDGES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic [NUM_EDGES-1:0] blocked
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      blocked <= '0;
    end else if (en) begin
      blocked <= blocked | chk_mask;
    end
  end

endmodule

// File: rtl/prm_obstacle_scan.sv
// Streams obstacle codes onto the shared checker bus and collects the blocked-edge bitmap.
// Handshake: a code transfers on any rising edge where obs_valid and obs_ready are both high.
module prm_obstacle_scan
  import prm_scan_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEFAULT,
  parameter int NUM_EDGES = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 obs_valid,
  input  logic [CODE_W-1:0]    obs_code,
  input  logic                 obs_last,
  output logic                 obs_ready,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic [NUM_EDGES-1:0] blocked,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     obs_count,
  output logic [1:0]           state
);

  scan_state_t state_q, state_d;
  logic        pend;
  logic        hs;
  logic        clr;

  assign hs  = obs_valid && obs_ready;
  assign clr = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (hs && obs_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obs_ready = (state_q == SCAN);
    busy      = (state_q == SCAN) || (state_q == FLUSH);
    done      = (state_q == DONE);
    state     = state_q;
  end

  // pend marks that chk_mask reflects a freshly accepted code this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_code  <= '0;
      pend      <= 1'b0;
      obs_count <= '0;
    end else begin
      pend <= hs;
      if (hs) begin
        chk_code <= obs_code;
      end
      if (clr) begin
        obs_count <= '0;
      end else if (hs && (obs_count != '1)) begin
        obs_count <= obs_count + CNT_W'(1);
      end
    end
  end

  prm_edge_accum #(
    .NUM_EDGES(NUM_EDGES)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (pend),
    .chk_mask (chk_mask),
    .blocked  (blocked)
  );

endmodule
